encoding_block: RTL and testbench
=================================

Name: encoding_block

Overview:
- Transmit-side counterpart of the lane decoder.
- Accepts one byte per lane per clock from the lane-distribution logic and accumulates a full block per lane.
- Prepends the sync header (transport data vs ordered set) and presents the 132-bit encoded word per lane to the serializer/PHY interface.
- Supports Gen2 (64b/66b), Gen3 (128b/132b) and Gen4 (16-byte block, no header) framing.

Parameters:
- GEN4, 0, gen_speed code for Gen4
- GEN3, 1, gen_speed code for Gen3
- GEN2, 2, gen_speed code for Gen2

Ports:
- enc_clk  input  1  block clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable_enc  input  1  byte strobe; lane_x_tx and data_os are valid this cycle
- gen_speed  input  2  link generation (0 = Gen4, 1 = Gen3, 2 = Gen2, 3 = reserved)
- data_os  input  1  1 = transport-layer data block, 0 = ordered-set block
- lane_0_tx  input  8  lane 0 byte
- lane_1_tx  input  8  lane 1 byte
- lane_0_tx_enc  output  132  lane 0 encoded block
- lane_1_tx_enc  output  132  lane 1 encoded block
- enc_valid  output  1  one-cycle pulse; encoded blocks valid
- enc_busy  output  1  partial block held (byte index != 0)

Behaviour:
- Reset (rst = 1 at an enc_clk edge) clears:
  - lane_x_tx_enc = 0, enc_valid = 0, enc_busy = 0
  - byte index = 0, state = IDLE
  - both byte buffers and latched header type
- Block length (last_idx):
  - Gen2: 8 bytes, last_idx = 7
  - Gen3 and Gen4: 16 bytes, last_idx = 15
  - gen_speed = 3: no block ever completes; strobes are ignored; state stays IDLE.
- FSM states: IDLE, FILL.
  - IDLE + enable_enc: store byte 0, latch data_os and gen_speed, index = 1, go to FILL.
  - FILL + enable_enc: store byte at index, index + 1.
  - FILL, byte at last_idx stored: index = 0, go to IDLE, emit block next cycle.
  - FILL + enable_enc = 0: hold (gaps allowed); no timeout.
- Byte placement: lane byte i goes to bits [i*8+7 : i*8].
- Header placement, from the data_os latched at byte 0:
  - Gen3: bits [131:128] = 4'b0101 for data, 4'b1010 for ordered set.
  - Gen2: bits [65:64] = 2'b01 for data, 2'b10 for ordered set; bits [131:66] = 0.
  - Gen4: bits [131:128] = 0.
- Latency and output timing:
  - Last byte sampled at edge N → lane_x_tx_enc updated and enc_valid = 1 after edge N+1.
  - enc_valid deasserts the following cycle.
  - lane_x_tx_enc holds its value until the next block.
- A strobe in the emit cycle starts the next block; back-to-back blocks run with no bubble.
- gen_speed or data_os changes mid-block: ignored; the values latched at byte 0 govern the whole block.
- enc_busy = 1 whenever state = FILL.
- Reset asserted mid-block: partial block discarded; no enc_valid.

Optional Feature:
- Macro: ENCODER_SCRAMBLE_EN.
- Defined:
  - Payload bits (not header bits) of each lane are XORed with a per-lane 23-bit LFSR, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
  - LFSR seed is 23'h1DBFBC at reset; it advances 8 steps per accepted byte.
  - Ordered-set blocks are not scrambled, and the LFSR does not advance on them.
- Undefined: payload passes unscrambled; no LFSR logic is present.

Decomposition:
- Shared package holds:
  - GEN2/GEN3/GEN4 codes
  - header constants HDR_DATA_G3 = 4'b0101, HDR_OS_G3 = 4'b1010, HDR_DATA_G2 = 2'b01, HDR_OS_G2 = 2'b10
  - block-length constants
  - LFSR seed and polynomial
- One sub-module is natural: lane_scrambler (byte-wide LFSR step plus XOR), instantiated once per lane under ENCODER_SCRAMBLE_EN.

Test Plan:
- Gen3 data block: rst pulse, gen_speed = 1, data_os = 1, 16 consecutive strobes with lane_0 bytes 0x00..0x0F and lane_1 bytes 0xF0..0xFF → one cycle after the last byte, enc_valid = 1 for one cycle; lane_0_tx_enc = {4'b0101, 128'h0F0E…0100}; lane_1_tx_enc = {4'b0101, 128'hFFFE…F1F0}.
- Gen2 ordered set: gen_speed = 2, data_os = 0, 8 bytes 0xA5 → lane_0_tx_enc[65:64] = 2'b10, [63:0] = 64'hA5A5A5A5A5A5A5A5, [131:66] = 0.
- Gapped input with a mid-block change: Gen3, strobe only on alternate cycles, and toggle data_os after byte 3 → exactly one enc_valid, after the 16th strobe; header is set by the byte-0 data_os.
- Back-to-back blocks: 32 continuous Gen3 strobes → enc_valid pulses 16 cycles apart; no byte is lost.
- Mid-block reset: rst asserted after byte 5, then a new 16-byte block → a single enc_valid containing only the new block's bytes; enc_busy = 0 during rst.
- Reserved speed: gen_speed = 3 with 20 strobes → enc_valid never asserts; lane_x_tx_enc stay 0.

Source files
------------

// File: rtl/encoding_block_pkg.sv
// Shared constants and helpers for the lane block encoder: generation codes,
// sync headers, block lengths and the scrambler LFSR definition.
package encoding_block_pkg;

  localparam int LANES = 2;

  localparam logic [1:0] GEN4     = 2'd0;
  localparam logic [1:0] GEN3     = 2'd1;
  localparam logic [1:0] GEN2     = 2'd2;
  localparam logic [1:0] GEN_RSVD = 2'd3;

  localparam logic [3:0] HDR_DATA_G3 = 4'b0101;
  localparam logic [3:0] HDR_OS_G3   = 4'b1010;
  localparam logic [1:0] HDR_DATA_G2 = 2'b01;
  localparam logic [1:0] HDR_OS_G2   = 2'b10;

  localparam logic [3:0] LAST_IDX_G2  = 4'd7;
  localparam logic [3:0] LAST_IDX_G34 = 4'd15;

  // x^23+x^21+x^16+x^8+x^5+x^2+1 as feedback taps on state bits 22,20,15,7,4,1
  localparam logic [22:0] LFSR_SEED = 23'h1DBFBC;
  localparam logic [22:0] LFSR_TAPS = 23'h508092;

  function automatic logic [3:0] last_idx(input logic [1:0] gen);
    return (gen == GEN2) ? LAST_IDX_G2 : LAST_IDX_G34;
  endfunction

  function automatic logic [131:0] build_block(input logic [1:0] gen,
                                               input logic hdr_data,
                                               input logic [127:0] payload);
    logic [131:0] blk;
    blk = '0;
    case (gen)
      GEN3:    blk = {(hdr_data ? HDR_DATA_G3 : HDR_OS_G3), payload};
      GEN2:    blk = {66'd0, (hdr_data ? HDR_DATA_G2 : HDR_OS_G2), payload[63:0]};
      GEN4:    blk = {4'd0, payload};
      default: blk = '0;
    endcase
    return blk;
  endfunction

endpackage

// File: rtl/encoding_block_scrambler.sv
// Per-lane byte scrambler: XORs each byte with eight LFSR output bits and
// advances the LFSR eight steps when told to.
module lane_scrambler
  import encoding_block_pkg::*;
(
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       bypass,
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  logic [22:0] lfsr_reg;
  logic [22:0] lfsr_next;
  logic [7:0]  key_stream;

  always_comb begin
    lfsr_next  = lfsr_reg;
    key_stream = '0;
    for (int k = 0; k < 8; k++) begin
      key_stream[k] = lfsr_next[22];
      lfsr_next     = {lfsr_next[21:0], ^(lfsr_next & LFSR_TAPS)};
    end
  end

  assign byte_out = bypass ? byte_in : (byte_in ^ key_stream);

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (advance) begin
      lfsr_reg <= lfsr_next;
    end
  end

endmodule

// File: rtl/encoding_block.sv
// Transmit-side block encoder: accumulates one byte per lane per strobe and
// emits sync-header-framed blocks. Define ENCODER_SCRAMBLE_EN to scramble payload.
module encoding_block
  import encoding_block_pkg::*;
(
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         enable_enc,
  input  logic [1:0]   gen_speed,
  input  logic         data_os,
  input  logic [7:0]   lane_0_tx,
  input  logic [7:0]   lane_1_tx,
  output logic [131:0] lane_0_tx_enc,
  output logic [131:0] lane_1_tx_enc,
  output logic         enc_valid,
  output logic         enc_busy
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_FILL = 1'b1;

  logic [0:0] state_reg;
  logic [3:0] idx_reg;
  logic       hdr_data_reg;
  logic [1:0] gen_reg;
  logic       emit_reg;
  logic       valid_reg;

  logic                    accept;
  logic [3:0]              wr_idx;
  logic [LANES-1:0][7:0]   lane_byte;
  logic [LANES-1:0][131:0] lane_enc;

  assign lane_byte[0] = lane_0_tx;
  assign lane_byte[1] = lane_1_tx;

  // Reserved speed never opens a block, so its strobes are simply dropped.
  assign accept = enable_enc && ((state_reg == STATE_FILL) || (gen_speed != GEN_RSVD));
  assign wr_idx = (state_reg == STATE_FILL) ? idx_reg : 4'd0;

`ifdef ENCODER_SCRAMBLE_EN
  logic blk_data;
  assign blk_data = (state_reg == STATE_FILL) ? hdr_data_reg : data_os;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [127:0] buf_reg;
      logic [131:0] enc_reg;
      logic [7:0]   pay_byte;

`ifdef ENCODER_SCRAMBLE_EN
      lane_scrambler u_scrambler (
        .enc_clk  (enc_clk),
        .rst      (rst),
        .advance  (accept && blk_data),
        .bypass   (!blk_data),
        .byte_in  (lane_byte[gi]),
        .byte_out (pay_byte)
      );
`else
      assign pay_byte = lane_byte[gi];
`endif

      // Block assembly reads the previous buffer contents, so a strobe in the
      // emit cycle may already overwrite byte 0 of the next block.
      always_ff @(posedge enc_clk) begin
        if (rst) begin
          buf_reg <= '0;
          enc_reg <= '0;
        end else begin
          if (accept) begin
            buf_reg[{wr_idx, 3'b000} +: 8] <= pay_byte;
          end
          if (emit_reg) begin
            enc_reg <= build_block(gen_reg, hdr_data_reg, buf_reg);
          end
        end
      end

      assign lane_enc[gi] = enc_reg;
    end
  endgenerate

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      state_reg    <= STATE_IDLE;
      idx_reg      <= '0;
      hdr_data_reg <= 1'b0;
      gen_reg      <= GEN4;
      emit_reg     <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      emit_reg  <= 1'b0;
      valid_reg <= emit_reg;
      case (state_reg)
        STATE_IDLE: begin
          if (accept) begin
            state_reg    <= STATE_FILL;
            idx_reg      <= 4'd1;
            hdr_data_reg <= data_os;
            gen_reg      <= gen_speed;
          end
        end
        default: begin
          if (enable_enc) begin
            if (idx_reg == last_idx(gen_reg)) begin
              state_reg <= STATE_IDLE;
              idx_reg   <= 4'd0;
              emit_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign lane_0_tx_enc = lane_enc[0];
  assign lane_1_tx_enc = lane_enc[1];
  assign enc_valid     = valid_reg;
  assign enc_busy      = (state_reg == STATE_FILL);

endmodule

// File: tb/tb_encoding_block.sv
// Scoreboard bench for encoding_block: a byte-level model predicts each block
// and the cycle it must appear; the monitor pops and compares on enc_valid.
module tb_encoding_block;

  logic         enc_clk = 1'b0;
  logic         rst;
  logic         enable_enc;
  logic [1:0]   gen_speed;
  logic         data_os;
  logic [7:0]   lane_0_tx;
  logic [7:0]   lane_1_tx;
  logic [131:0] lane_0_tx_enc;
  logic [131:0] lane_1_tx_enc;
  logic         enc_valid;
  logic         enc_busy;

  encoding_block dut (
    .enc_clk       (enc_clk),
    .rst           (rst),
    .enable_enc    (enable_enc),
    .gen_speed     (gen_speed),
    .data_os       (data_os),
    .lane_0_tx     (lane_0_tx),
    .lane_1_tx     (lane_1_tx),
    .lane_0_tx_enc (lane_0_tx_enc),
    .lane_1_tx_enc (lane_1_tx_enc),
    .enc_valid     (enc_valid),
    .enc_busy      (enc_busy)
  );

  always #5 enc_clk = ~enc_clk;

  int cyc = 0;
  always @(posedge enc_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_blk = 0;

  typedef struct {
    logic [131:0] l0;
    logic [131:0] l1;
    int           due;
  } exp_t;
  exp_t exp_q[$];

  // model state
  logic       m_fill = 1'b0;
  int         m_idx  = 0;
  logic       m_hdr  = 1'b0;
  logic [1:0] m_gen  = 2'd0;
  logic [7:0] m_b [2][16];

  task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [131:0] exp_block(input logic [1:0] g, input logic h,
                                             input logic [127:0] p);
    if (g == 2'd1) return {(h ? 4'b0101 : 4'b1010), p};
    if (g == 2'd2) return {66'd0, (h ? 2'b01 : 2'b10), p[63:0]};
    return {4'd0, p};
  endfunction

  task automatic drive(input logic en, input logic [7:0] b0, input logic [7:0] b1,
                       input logic dos, input logic [1:0] gs);
    logic [127:0] p0, p1;
    int last;
    @(negedge enc_clk);
    enable_enc = en;
    lane_0_tx  = b0;
    lane_1_tx  = b1;
    data_os    = dos;
    gen_speed  = gs;
    if (en) begin
      if (!m_fill) begin
        if (gs != 2'd3) begin
          m_fill  = 1'b1;
          m_hdr   = dos;
          m_gen   = gs;
          m_b[0][0] = b0;
          m_b[1][0] = b1;
          m_idx   = 1;
        end
      end else begin
        m_b[0][m_idx] = b0;
        m_b[1][m_idx] = b1;
        last = (m_gen == 2'd2) ? 7 : 15;
        if (m_idx == last) begin
          p0 = '0;
          p1 = '0;
          for (int i = 0; i <= last; i++) begin
            p0[i*8 +: 8] = m_b[0][i];
            p1[i*8 +: 8] = m_b[1][i];
          end
          exp_q.push_back('{l0: exp_block(m_gen, m_hdr, p0),
                            l1: exp_block(m_gen, m_hdr, p1),
                            due: cyc + 2});
          m_fill = 1'b0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 8'h00, 1'b0, 2'd1);
  endtask

  task automatic do_reset();
    @(negedge enc_clk);
    rst        = 1'b1;
    enable_enc = 1'b0;
    m_fill     = 1'b0;
    m_idx      = 0;
    @(negedge enc_clk);
    check("busy_in_rst", {263'd0, enc_busy}, 264'd0);
    check("valid_in_rst", {263'd0, enc_valid}, 264'd0);
    rst = 1'b0;
  endtask

  // monitor: one line per emitted block
  initial begin
    exp_t e;
    forever begin
      @(negedge enc_clk);
      if (enc_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {263'd0, enc_valid}, 264'd0);
        end else begin
          e = exp_q.pop_front();
          n_blk++;
          check("valid_cycle", 264'(cyc), 264'(e.due));
          check("lane0_block", {132'd0, lane_0_tx_enc}, {132'd0, e.l0});
          check("lane1_block", {132'd0, lane_1_tx_enc}, {132'd0, e.l1});
          $display("block %0d at cycle %0d lane0=%h lane1=%h", n_blk, cyc, lane_0_tx_enc, lane_1_tx_enc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missed_valid", {263'd0, enc_valid}, 264'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] r0, r1;
    rst        = 1'b1;
    enable_enc = 1'b0;
    gen_speed  = 2'd1;
    data_os    = 1'b0;
    lane_0_tx  = 8'h00;
    lane_1_tx  = 8'h00;
    repeat (3) @(negedge enc_clk);
    check("rst_lane0", {132'd0, lane_0_tx_enc}, 264'd0);
    check("rst_lane1", {132'd0, lane_1_tx_enc}, 264'd0);
    check("rst_valid", {263'd0, enc_valid}, 264'd0);
    check("rst_busy", {263'd0, enc_busy}, 264'd0);
    rst = 1'b0;

    // Gen3 data block with known bytes
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 8'(8'hF0 + i), 1'b1, 2'd1);
    idle(3);
    check("g3_lit_lane0", {132'd0, lane_0_tx_enc},
          {132'd0, 4'b0101, 128'h0F0E0D0C0B0A09080706050403020100});
    check("g3_lit_lane1", {132'd0, lane_1_tx_enc},
          {132'd0, 4'b0101, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0});
    check("g3_busy_after", {263'd0, enc_busy}, 264'd0);

    // Gen2 ordered set
    for (int i = 0; i < 8; i++) drive(1'b1, 8'hA5, 8'h5A, 1'b0, 2'd2);
    idle(3);
    check("g2_lit_lane0", {132'd0, lane_0_tx_enc}, {132'd0, 66'd0, 2'b10, 64'hA5A5A5A5A5A5A5A5});
    check("g2_lit_lane1", {132'd0, lane_1_tx_enc}, {132'd0, 66'd0, 2'b10, 64'h5A5A5A5A5A5A5A5A});

    // Gapped Gen3 with data_os and gen_speed changing after byte 3
    for (int i = 0; i < 16; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      drive(1'b1, r0, r1, (i < 4), (i < 4) ? 2'd1 : 2'd2);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 2'd2);
      if (i == 5) check("busy_gapped", {263'd0, enc_busy}, 264'd1);
    end
    idle(3);
    check("gap_hdr", {260'd0, lane_0_tx_enc[131:128]}, {260'd0, 4'b0101});

    // Gen4 block
    for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 2'd0);
    idle(3);

    // Back-to-back Gen3 blocks, second one ordered set
    for (int i = 0; i < 32; i++) drive(1'b1, 8'($urandom), 8'($urandom), (i < 16), 2'd1);
    idle(3);

    // Mid-block reset discards the partial block
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hEE, 8'hDD, 1'b1, 2'd1);
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h30 + i), 8'(8'h60 + i), 1'b0, 2'd1);
    idle(3);

    // Reserved speed: strobes ignored
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 2'd3);
    idle(3);
    check("rsvd_lane0", {132'd0, lane_0_tx_enc}, 264'd0);
    check("rsvd_lane1", {132'd0, lane_1_tx_enc}, 264'd0);
    check("rsvd_busy", {263'd0, enc_busy}, 264'd0);

    idle(5);
    check("queue_drained", 264'(exp_q.size()), 264'd0);
    check("block_count", 264'(n_blk), 264'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
